// File: rtl/iq_issue_scheduler.sv
// Oldest-first issue selection from the IQ into two ALU slots and one memory slot.
// Optional ISSUE_PERF_EN build adds the issue_cnt / stall_cnt performance counters.
module iq_issue_scheduler #(
    parameter int IQ_DEPTH = 8,
    parameter int POS_W    = 3,
    parameter int MEM_LAT  = 2
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                flush,
    input  logic [POS_W-1:0]    head,
    input  logic [IQ_DEPTH-1:0] ready_alu,
    input  logic [IQ_DEPTH-1:0] ready_mem,
    input  logic [IQ_DEPTH-1:0] free_mask,
    input  logic [1:0]          alu_accept,
    input  logic                mem_accept,
    output logic [1:0]          alu_valid,
    output logic [POS_W-1:0]    alu_iqpos0,
    output logic [POS_W-1:0]    alu_iqpos1,
    output logic                mem_valid,
    output logic [POS_W-1:0]    mem_iqpos,
    output logic [IQ_DEPTH-1:0] issued_mask
`ifdef ISSUE_PERF_EN
    ,
    output logic [15:0]         issue_cnt,
    output logic [15:0]         stall_cnt
`endif
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(MEM_LAT - 1);

    logic [1:0]          r_alu_valid;
    logic [POS_W-1:0]    r_alu_pos0;
    logic [POS_W-1:0]    r_alu_pos1;
    logic                r_mem_valid;
    logic [POS_W-1:0]    r_mem_pos;
    logic [IQ_DEPTH-1:0] r_issued;
    logic [CNT_W-1:0]    r_busy;

    logic [IQ_DEPTH-1:0] w_held;
    logic [IQ_DEPTH-1:0] w_ca;
    logic [IQ_DEPTH-1:0] w_cm;
    logic                w_a_found0;
    logic                w_a_found1;
    logic [POS_W-1:0]    w_a_pos0;
    logic [POS_W-1:0]    w_a_pos1;
    logic                w_m_found;
    logic [POS_W-1:0]    w_m_pos;
    logic [1:0]          w_alu_ld;
    logic [1:0]          w_alu_valid_nxt;
    logic [POS_W-1:0]    w_alu_pos0_nxt;
    logic [POS_W-1:0]    w_alu_pos1_nxt;
    logic                w_mem_hs;
    logic                w_mem_ld;
    logic                w_mem_valid_nxt;
    logic [POS_W-1:0]    w_mem_pos_nxt;
    logic [CNT_W-1:0]    w_busy_nxt;
    logic [IQ_DEPTH-1:0] w_load_mask;

    function automatic logic [POS_W-1:0] age_pos(input logic [POS_W-1:0] base, input int unsigned off);
        logic [POS_W-1:0] w_off;
        w_off = off[POS_W-1:0];
        return base + w_off;
    endfunction

    // Positions currently parked in a slot are not eligible for another grant.
    always_comb begin
        w_held = '0;
        w_held[r_alu_pos0] = w_held[r_alu_pos0] | r_alu_valid[0];
        w_held[r_alu_pos1] = w_held[r_alu_pos1] | r_alu_valid[1];
        w_held[r_mem_pos]  = w_held[r_mem_pos]  | r_mem_valid;
    end

    assign w_cm = ready_mem & ~r_issued & ~free_mask & ~w_held;
    assign w_ca = ready_alu & ~r_issued & ~free_mask & ~w_held & ~ready_mem;

    // Age-ordered scan from head: two oldest ALU candidates, oldest memory candidate.
    always_comb begin
        w_a_found0 = 1'b0;
        w_a_found1 = 1'b0;
        w_a_pos0   = '0;
        w_a_pos1   = '0;
        w_m_found  = 1'b0;
        w_m_pos    = '0;
        for (int unsigned i = 0; i < IQ_DEPTH; i++) begin
            if (w_ca[age_pos(head, i)]) begin
                if (!w_a_found0) begin
                    w_a_found0 = 1'b1;
                    w_a_pos0   = age_pos(head, i);
                end else if (!w_a_found1) begin
                    w_a_found1 = 1'b1;
                    w_a_pos1   = age_pos(head, i);
                end else begin
                    w_a_found1 = w_a_found1;
                end
            end else begin
                w_a_found0 = w_a_found0;
            end
            if (w_cm[age_pos(head, i)] && !w_m_found) begin
                w_m_found = 1'b1;
                w_m_pos   = age_pos(head, i);
            end else begin
                w_m_found = w_m_found;
            end
        end
    end

    assign w_alu_ld = ~r_alu_valid | alu_accept;

    // ALU slot refill: oldest candidate to the lowest-numbered free slot.
    always_comb begin
        w_alu_valid_nxt = r_alu_valid;
        w_alu_pos0_nxt  = r_alu_pos0;
        w_alu_pos1_nxt  = r_alu_pos1;
        w_load_mask     = '0;
        if (w_alu_ld[0]) begin
            w_alu_valid_nxt[0] = w_a_found0;
            w_alu_pos0_nxt     = w_a_found0 ? w_a_pos0 : '0;
            w_load_mask[w_a_pos0] = w_a_found0;
            if (w_alu_ld[1]) begin
                w_alu_valid_nxt[1] = w_a_found1;
                w_alu_pos1_nxt     = w_a_found1 ? w_a_pos1 : '0;
                w_load_mask[w_a_pos1] = w_load_mask[w_a_pos1] | w_a_found1;
            end else begin
                w_alu_valid_nxt[1] = r_alu_valid[1];
            end
        end else begin
            if (w_alu_ld[1]) begin
                w_alu_valid_nxt[1] = w_a_found0;
                w_alu_pos1_nxt     = w_a_found0 ? w_a_pos0 : '0;
                w_load_mask[w_a_pos0] = w_a_found0;
            end else begin
                w_alu_valid_nxt[1] = r_alu_valid[1];
            end
        end
    end

    // Busy count is judged on its post-edge value, so MEM_LAT=1 allows back-to-back grants.
    always_comb begin
        w_mem_hs = r_mem_valid & mem_accept;
        if (w_mem_hs) begin
            w_busy_nxt = BUSY_LOAD;
        end else if (r_busy != {CNT_W{1'b0}}) begin
            w_busy_nxt = r_busy - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            w_busy_nxt = r_busy;
        end
        w_mem_ld = (~r_mem_valid | mem_accept) & (w_busy_nxt == {CNT_W{1'b0}});
    end

    // Memory slot refill; an accepted grant that cannot be replaced just drops valid.
    always_comb begin
        w_mem_valid_nxt = r_mem_valid;
        w_mem_pos_nxt   = r_mem_pos;
        if (w_mem_ld) begin
            w_mem_valid_nxt = w_m_found;
            w_mem_pos_nxt   = w_m_found ? w_m_pos : '0;
        end else if (w_mem_hs) begin
            w_mem_valid_nxt = 1'b0;
            w_mem_pos_nxt   = '0;
        end else begin
            w_mem_valid_nxt = r_mem_valid;
        end
    end

    // Slot, issued-mask and busy-counter state; flush squashes everything pending.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_alu_valid <= 2'b00;
            r_alu_pos0  <= '0;
            r_alu_pos1  <= '0;
            r_mem_valid <= 1'b0;
            r_mem_pos   <= '0;
            r_issued    <= '0;
            r_busy      <= '0;
        end else if (flush) begin
            r_alu_valid <= 2'b00;
            r_alu_pos0  <= '0;
            r_alu_pos1  <= '0;
            r_mem_valid <= 1'b0;
            r_mem_pos   <= '0;
            r_issued    <= '0;
            r_busy      <= '0;
        end else begin
            r_alu_valid <= w_alu_valid_nxt;
            r_alu_pos0  <= w_alu_pos0_nxt;
            r_alu_pos1  <= w_alu_pos1_nxt;
            r_mem_valid <= w_mem_valid_nxt;
            r_mem_pos   <= w_mem_pos_nxt;
            r_issued    <= (r_issued | w_load_mask |
                           ({IQ_DEPTH{w_mem_ld & w_m_found}} & (IQ_DEPTH'(1) << w_m_pos))) & ~free_mask;
            r_busy      <= w_busy_nxt;
        end
    end

    assign alu_valid   = r_alu_valid;
    assign alu_iqpos0  = r_alu_pos0;
    assign alu_iqpos1  = r_alu_pos1;
    assign mem_valid   = r_mem_valid;
    assign mem_iqpos   = r_mem_pos;
    assign issued_mask = r_issued;

`ifdef ISSUE_PERF_EN
    logic [15:0] r_issue_cnt;
    logic [15:0] r_stall_cnt;
    logic [1:0]  w_hs_cnt;
    logic        w_stall;

    function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] inc);
        logic [16:0] w_sum;
        w_sum = {1'b0, cnt} + {15'd0, inc};
        return w_sum[16] ? 16'hFFFF : w_sum[15:0];
    endfunction

    assign w_hs_cnt = {1'b0, r_alu_valid[0] & alu_accept[0]} +
                      {1'b0, r_alu_valid[1] & alu_accept[1]} +
                      {1'b0, r_mem_valid & mem_accept};
    assign w_stall  = (|(r_alu_valid & ~alu_accept)) | (r_mem_valid & ~mem_accept);

    // Saturating performance counters; deliberately blind to flush.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_issue_cnt <= 16'd0;
            r_stall_cnt <= 16'd0;
        end else begin
            r_issue_cnt <= sat_add(r_issue_cnt, w_hs_cnt);
            r_stall_cnt <= sat_add(r_stall_cnt, {1'b0, w_stall});
        end
    end

    assign issue_cnt = r_issue_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_iq_issue_scheduler.sv
// Randomised and directed bench for iq_issue_scheduler against an age-list reference model.
module tb_iq_issue_scheduler;
    localparam int LAT = 3;

    logic       clk = 1'b0;
    logic       nrst;
    logic       flush;
    logic [2:0] head;
    logic [7:0] ready_alu, ready_mem, free_mask;
    logic [1:0] alu_accept;
    logic       mem_accept;
    logic [1:0] alu_valid;
    logic [2:0] alu_iqpos0, alu_iqpos1, mem_iqpos;
    logic       mem_valid;
    logic [7:0] issued_mask;
`ifdef ISSUE_PERF_EN
    logic [15:0] issue_cnt, stall_cnt;
`endif

    iq_issue_scheduler #(.IQ_DEPTH(8), .POS_W(3), .MEM_LAT(LAT)) dut (
        .clk(clk), .nrst(nrst), .flush(flush), .head(head),
        .ready_alu(ready_alu), .ready_mem(ready_mem), .free_mask(free_mask),
        .alu_accept(alu_accept), .mem_accept(mem_accept),
        .alu_valid(alu_valid), .alu_iqpos0(alu_iqpos0), .alu_iqpos1(alu_iqpos1),
        .mem_valid(mem_valid), .mem_iqpos(mem_iqpos), .issued_mask(issued_mask)
`ifdef ISSUE_PERF_EN
        , .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: slot 0/1 = ALUs, slot 2 = memory.
    bit m_v[3];
    int m_p[3];
    bit m_iss[8];
    int m_last_hs;
    int edge_n = 0;
    int m_icnt, m_scnt;

    task automatic model_reset();
        for (int s = 0; s < 3; s++) begin m_v[s] = 1'b0; m_p[s] = 0; end
        for (int p = 0; p < 8; p++) m_iss[p] = 1'b0;
        m_last_hs = -100;
        m_icnt = 0;
        m_scnt = 0;
    endtask

    function automatic logic [7:0] exp_iss();
        logic [7:0] v;
        for (int p = 0; p < 8; p++) v[p] = m_iss[p];
        return v;
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, settle 1 time unit.
    task automatic step(input bit fl, input int hd, input logic [7:0] ra, input logic [7:0] rm,
                        input logic [7:0] fm, input logic [1:0] aa, input bit ma);
        bit nv[3];
        int np[3];
        bit held[8];
        int ca[$];
        int cm[$];
        int loaded[$];
        int ai, p;
        bit hs_now;
        flush = fl; head = hd[2:0]; ready_alu = ra; ready_mem = rm;
        free_mask = fm; alu_accept = aa; mem_accept = ma;
        for (int q = 0; q < 8; q++) held[q] = 1'b0;
        for (int s = 0; s < 3; s++) if (m_v[s]) held[m_p[s]] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            p = (hd + i) % 8;
            if (!m_iss[p] && !fm[p] && !held[p]) begin
                if (rm[p]) cm.push_back(p);
                else if (ra[p]) ca.push_back(p);
            end
        end
        hs_now = m_v[2] && ma;
        m_icnt += int'(m_v[0] && aa[0]) + int'(m_v[1] && aa[1]) + int'(hs_now);
        if (m_icnt > 65535) m_icnt = 65535;
        if ((m_v[0] && !aa[0]) || (m_v[1] && !aa[1]) || (m_v[2] && !ma)) m_scnt++;
        if (m_scnt > 65535) m_scnt = 65535;
        for (int s = 0; s < 3; s++) begin nv[s] = m_v[s]; np[s] = m_p[s]; end
        if (fl) begin
            for (int s = 0; s < 3; s++) nv[s] = 1'b0;
            for (int q = 0; q < 8; q++) m_iss[q] = 1'b0;
            m_last_hs = -100;
        end else begin
            ai = 0;
            for (int k = 0; k < 2; k++) begin
                if (!m_v[k] || aa[k]) begin
                    if (ai < ca.size()) begin
                        nv[k] = 1'b1; np[k] = ca[ai]; loaded.push_back(ca[ai]); ai++;
                    end else nv[k] = 1'b0;
                end
            end
            if (hs_now) m_last_hs = edge_n + 1;
            if ((!m_v[2] || ma) && (edge_n + 1 >= m_last_hs + LAT - 1)) begin
                if (cm.size() > 0) begin
                    nv[2] = 1'b1; np[2] = cm[0]; loaded.push_back(cm[0]);
                end else nv[2] = 1'b0;
            end else if (hs_now) nv[2] = 1'b0;
            foreach (loaded[j]) m_iss[loaded[j]] = 1'b1;
            for (int q = 0; q < 8; q++) if (fm[q]) m_iss[q] = 1'b0;
        end
        @(posedge clk);
        edge_n++;
        for (int s = 0; s < 3; s++) begin m_v[s] = nv[s]; m_p[s] = np[s]; end
        #1;
    endtask

    task automatic cleanup();
        step(1'b1, 0, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0);
    endtask

    task automatic test_reset();
        nrst = 1'b0; flush = 1'b0; head = 3'd0; ready_alu = 8'h00; ready_mem = 8'h00;
        free_mask = 8'h00; alu_accept = 2'b00; mem_accept = 1'b0;
        model_reset();
        #12;
        checks++; if (alu_valid !== 2'b00) begin errors++; $display("FAIL reset_alu_valid: got %b expected 00", alu_valid); end
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid: got %b expected 0", mem_valid); end
        checks++; if (issued_mask !== 8'h00) begin errors++; $display("FAIL reset_issued: got %h expected 00", issued_mask); end
        checks++; if ({alu_iqpos0, alu_iqpos1, mem_iqpos} !== 9'd0) begin errors++; $display("FAIL reset_pos: got %0d %0d %0d expected 0 0 0", alu_iqpos0, alu_iqpos1, mem_iqpos); end
        @(negedge clk); nrst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        step(1'b0, 0, 8'b0000_0110, 8'h00, 8'h00, 2'b11, 1'b1);
        checks++; if (alu_valid !== 2'b11) begin errors++; $display("FAIL basic_valid: got %b expected 11", alu_valid); end
        checks++; if (alu_iqpos0 !== 3'd1) begin errors++; $display("FAIL basic_pos0: got %0d expected 1", alu_iqpos0); end
        checks++; if (alu_iqpos1 !== 3'd2) begin errors++; $display("FAIL basic_pos1: got %0d expected 2", alu_iqpos1); end
        checks++; if (issued_mask !== 8'b0000_0110) begin errors++; $display("FAIL basic_issued: got %b expected 00000110", issued_mask); end
    endtask

    task automatic test_wrap();
        step(1'b0, 0, 8'h00, 8'h00, 8'b0000_0110, 2'b11, 1'b1);
        checks++; if (alu_valid !== 2'b00) begin errors++; $display("FAIL drain_valid: got %b expected 00", alu_valid); end
        step(1'b0, 6, 8'b1000_0001, 8'h00, 8'h00, 2'b11, 1'b1);
        checks++; if (alu_valid !== 2'b11) begin errors++; $display("FAIL wrap_valid: got %b expected 11", alu_valid); end
        checks++; if (alu_iqpos0 !== 3'd7) begin errors++; $display("FAIL wrap_pos0: got %0d expected 7", alu_iqpos0); end
        checks++; if (alu_iqpos1 !== 3'd0) begin errors++; $display("FAIL wrap_pos1: got %0d expected 0", alu_iqpos1); end
        cleanup();
    endtask

    task automatic test_stall();
        step(1'b0, 0, 8'h08, 8'h00, 8'h00, 2'b11, 1'b1);
        checks++; if (alu_valid[0] !== 1'b1 || alu_iqpos0 !== 3'd3) begin errors++; $display("FAIL stall_grant: got v=%b pos=%0d expected v=1 pos=3", alu_valid[0], alu_iqpos0); end
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 0, 8'h08, 8'h00, 8'h00, 2'b10, 1'b1);
            checks++; if (alu_valid[0] !== 1'b1 || alu_iqpos0 !== 3'd3) begin errors++; $display("FAIL stall_hold: cycle %0d got v=%b pos=%0d expected v=1 pos=3", c, alu_valid[0], alu_iqpos0); end
            checks++; if (alu_valid[1] === 1'b1 && alu_iqpos1 === 3'd3) begin errors++; $display("FAIL stall_dup: cycle %0d got pos 3 on ALU1 expected not granted", c); end
        end
        step(1'b0, 0, 8'h48, 8'h00, 8'h00, 2'b11, 1'b1);
        checks++; if (alu_valid !== 2'b01 || alu_iqpos0 !== 3'd6) begin errors++; $display("FAIL stall_release: got v=%b pos0=%0d expected v=01 pos0=6", alu_valid, alu_iqpos0); end
        cleanup();
    endtask

    task automatic test_mem_lat();
        logic [3:0] exp_v;
        exp_v = 4'b1001;
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 0, 8'h00, 8'h30, 8'h00, 2'b11, 1'b1);
            checks++; if (mem_valid !== exp_v[c]) begin errors++; $display("FAIL memlat_valid: edge %0d got %b expected %b", c, mem_valid, exp_v[c]); end
        end
        checks++; if (mem_iqpos !== 3'd5) begin errors++; $display("FAIL memlat_pos: got %0d expected 5", mem_iqpos); end
        cleanup();
    endtask

    task automatic test_free_same();
        step(1'b0, 0, 8'h04, 8'h00, 8'h00, 2'b11, 1'b1);
        checks++; if (alu_valid[0] !== 1'b1 || alu_iqpos0 !== 3'd2) begin errors++; $display("FAIL free_grant: got v=%b pos=%0d expected v=1 pos=2", alu_valid[0], alu_iqpos0); end
        step(1'b0, 0, 8'h04, 8'h00, 8'h04, 2'b11, 1'b1);
        checks++; if (issued_mask[2] !== 1'b0) begin errors++; $display("FAIL free_clear: got %b expected 0", issued_mask[2]); end
        checks++; if (alu_valid !== 2'b00) begin errors++; $display("FAIL free_noregrant: got %b expected 00", alu_valid); end
        step(1'b0, 0, 8'h04, 8'h00, 8'h00, 2'b11, 1'b1);
        checks++; if (alu_valid[0] !== 1'b1 || alu_iqpos0 !== 3'd2 || issued_mask[2] !== 1'b1) begin errors++; $display("FAIL free_regrant: got v=%b pos=%0d iss=%b expected v=1 pos=2 iss=1", alu_valid[0], alu_iqpos0, issued_mask[2]); end
        cleanup();
    endtask

    task automatic test_flush();
        step(1'b0, 0, 8'hFF, 8'h80, 8'h00, 2'b11, 1'b0);
        step(1'b0, 0, 8'hFF, 8'h80, 8'h00, 2'b11, 1'b0);
        step(1'b0, 0, 8'hFF, 8'h80, 8'h00, 2'b11, 1'b0);
        step(1'b0, 0, 8'hFF, 8'h80, 8'h00, 2'b01, 1'b0);
        checks++; if ({alu_valid, mem_valid} !== 3'b111 || issued_mask !== 8'hFF) begin errors++; $display("FAIL flush_setup: got v=%b%b iss=%h expected v=111 iss=ff", alu_valid, mem_valid, issued_mask); end
        step(1'b1, 0, 8'hFF, 8'hFF, 8'h00, 2'b11, 1'b1);
        checks++; if ({alu_valid, mem_valid} !== 3'b000) begin errors++; $display("FAIL flush_valid: got %b%b expected 000", alu_valid, mem_valid); end
        checks++; if (issued_mask !== 8'h00) begin errors++; $display("FAIL flush_issued: got %h expected 00", issued_mask); end
        step(1'b0, 0, 8'h00, 8'h01, 8'h00, 2'b11, 1'b1);
        checks++; if (mem_valid !== 1'b1 || mem_iqpos !== 3'd0) begin errors++; $display("FAIL flush_busyclr: got v=%b pos=%0d expected v=1 pos=0", mem_valid, mem_iqpos); end
        cleanup();
    endtask

    task automatic test_random(input int n);
        logic [1:0] aa;
        for (int c = 0; c < n; c++) begin
            aa = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
            step(1'($urandom_range(0, 39) == 0), int'($urandom_range(0, 7)), 8'($urandom),
                 8'($urandom & $urandom), 8'($urandom & $urandom & $urandom), aa,
                 1'($urandom_range(0, 2) != 0));
            checks++; if (alu_valid !== {m_v[1], m_v[0]}) begin errors++; $display("FAIL rnd_alu_valid: cyc %0d got %b expected %b", c, alu_valid, {m_v[1], m_v[0]}); end
            checks++; if (m_v[0] && alu_iqpos0 !== 3'(m_p[0])) begin errors++; $display("FAIL rnd_pos0: cyc %0d got %0d expected %0d", c, alu_iqpos0, m_p[0]); end
            checks++; if (m_v[1] && alu_iqpos1 !== 3'(m_p[1])) begin errors++; $display("FAIL rnd_pos1: cyc %0d got %0d expected %0d", c, alu_iqpos1, m_p[1]); end
            checks++; if (mem_valid !== m_v[2]) begin errors++; $display("FAIL rnd_mem_valid: cyc %0d got %b expected %b", c, mem_valid, m_v[2]); end
            checks++; if (m_v[2] && mem_iqpos !== 3'(m_p[2])) begin errors++; $display("FAIL rnd_mem_pos: cyc %0d got %0d expected %0d", c, mem_iqpos, m_p[2]); end
            checks++; if (issued_mask !== exp_iss()) begin errors++; $display("FAIL rnd_issued: cyc %0d got %h expected %h", c, issued_mask, exp_iss()); end
        end
    endtask

    task automatic test_reset_mid();
        #3 nrst = 1'b0;
        #1;
        model_reset();
        checks++; if ({alu_valid, mem_valid} !== 3'b000 || issued_mask !== 8'h00) begin errors++; $display("FAIL midreset: got v=%b%b iss=%h expected 000 00", alu_valid, mem_valid, issued_mask); end
        @(posedge clk); #1;
        nrst = 1'b1;
        step(1'b0, 0, 8'h03, 8'h00, 8'h00, 2'b11, 1'b1);
        checks++; if (alu_valid !== 2'b11 || alu_iqpos0 !== 3'd0 || alu_iqpos1 !== 3'd1) begin errors++; $display("FAIL midreset_first: got v=%b p0=%0d p1=%0d expected 11 0 1", alu_valid, alu_iqpos0, alu_iqpos1); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_mem_lat();
        test_free_same();
        test_flush();
        test_random(600);
        test_reset_mid();
        test_random(300);
`ifdef ISSUE_PERF_EN
        checks++; if (issue_cnt !== 16'(m_icnt)) begin errors++; $display("FAIL perf_issue: got %0d expected %0d", issue_cnt, m_icnt); end
        checks++; if (stall_cnt !== 16'(m_scnt)) begin errors++; $display("FAIL perf_stall: got %0d expected %0d", stall_cnt, m_scnt); end
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
